g_calc_scheduler: RTL
=====================

G_CALC_SCHEDULER -- requirements
Module: g_calc_scheduler

Interface
REQ-001 Parameter N, default 16: width of each real and imaginary sample.
REQ-002 Parameter PRE_BEAT, default 1: number of zero-data warm-up beats sent before each 8-beat block; legal values 0 and 1.
REQ-003 Parameter TIMEOUT, default 64: maximum cycles in S_WAIT before the block is abandoned.
REQ-004 clk  input  1  the single clock; all logic SHALL be on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 s0_valid / s0_ready  input / output  1 / 1  source 0 handshake.
REQ-007 s0_r, s0_i  input  N / N  source 0 Hq sample, signed.
REQ-008 s1_valid / s1_ready, s1_r, s1_i  same as source 0, for source 1.
REQ-009 Hq_in_valid  output  1  beat strobe to the G-matrix calculator.
REQ-010 Hq_in_r, Hq_in_i  output  N / N  forwarded Hq sample, signed.
REQ-011 G_row_valid  input  1  row strobe from the calculator.
REQ-012 done  input  1  block-complete pulse from the calculator.
REQ-013 row_src  output  1  source id of the block whose G rows are being output.
REQ-014 row_idx  output  2  index (0-3) of the current G row.
REQ-015 busy  output  1  high in every state except S_IDLE.
REQ-016 blk_cnt0, blk_cnt1  output  8 / 8  completed blocks per source.
REQ-017 err  output  1  sticky protocol-error flag.

Function
REQ-018 The FSM SHALL have the states S_IDLE, S_PRE, S_LOAD and S_WAIT.
REQ-019 S_IDLE arbitration: one valid source SHALL be granted; if both are valid, the source not granted last SHALL be granted (round-robin); last_grant SHALL reset to 1, so source 0 wins the first tie.
REQ-020 On grant, the grant SHALL be registered into gnt and the FSM SHALL go to S_PRE if PRE_BEAT=1, otherwise to S_LOAD.
REQ-021 S_PRE SHALL last 1 cycle and drive Hq_in_valid=1 with Hq_in_r/i=0 on the next edge, then go to S_LOAD.
REQ-022 S_LOAD: s{gnt}_ready=1 and the other ready=0; all readys SHALL be 0 in every other state.
REQ-023 A transfer occurs when valid and ready are both high; the beat SHALL appear registered on Hq_in_valid/r/i exactly 1 cycle later.
REQ-024 With no transfer in a cycle, Hq_in_valid SHALL be 0 and Hq_in_r/i SHALL hold their values.
REQ-025 A 3-bit beat counter SHALL count transfers; the 8th transfer SHALL move the FSM to S_WAIT and clear the counter.
REQ-026 S_WAIT: row_src=gnt; row_idx SHALL increment (wrapping mod 4) on each G_row_valid, starting at 0 for each block.
REQ-027 done in S_WAIT: blk_cnt{gnt} SHALL increment, saturating at 255; last_grant<=gnt; FSM SHALL go to S_IDLE.
REQ-028 A new grant SHALL NOT occur in the cycle done is seen; the earliest new grant is the following cycle.
REQ-029 A wait counter SHALL count cycles in S_WAIT; reaching TIMEOUT without done SHALL set err, leave blk_cnt unchanged, update last_grant and return to S_IDLE.
REQ-030 G_row_valid or done seen outside S_WAIT SHALL set err and SHALL NOT otherwise change state.
REQ-031 err SHALL be cleared only by reset.
REQ-032 done and TIMEOUT expiring in the same cycle: done SHALL take priority and err SHALL stay unchanged.

Reset
REQ-033 rst_n low SHALL force immediately: state=S_IDLE, all readys=0, Hq_in_valid=0, Hq_in_r/i=0, row_src=0, row_idx=0, busy=0, blk_cnt0=blk_cnt1=0, err=0, last_grant=1, all counters=0.
REQ-034 Reset during S_LOAD or S_WAIT SHALL discard the in-flight block; nothing SHALL be replayed after reset is released.

Verification
REQ-035 Only s0 valid, data 1..8, model returns 4 G_row_valid then done -> 1 zero pre-beat, then Hq_in_r 1..8 each 1 cycle after acceptance, row_src=0, row_idx 0,1,2,3, blk_cnt0=1.
REQ-036 s0 and s1 held valid continuously for 4 blocks -> grants in order 0,1,0,1; blk_cnt0=2, blk_cnt1=2.
REQ-037 s0_valid deasserted during beats 3-5 -> Hq_in_valid gaps match exactly, all 8 beats forwarded in order, no extra beat.
REQ-038 done withheld -> after 64 cycles in S_WAIT, err=1, busy=0, blk_cnt unchanged; next block still serviced, err stays 1.
REQ-039 rst_n pulsed low at beat 5 of a block -> all outputs at reset values in the same cycle; after release, a fresh block sends 8 beats from beat 0.
REQ-040 G_row_valid pulsed while in S_IDLE -> err=1, state stays S_IDLE.

Source files
------------

// File: rtl/g_calc_scheduler_if.sv
// Bundle of the two Hq sources, the calculator-facing beat/row signals and status.
// slave is the scheduler's view; master is the view of whatever drives it.
interface g_calc_scheduler_if #(
  parameter int N = 16
);
  logic                s0_valid;
  logic                s0_ready;
  logic signed [N-1:0] s0_r;
  logic signed [N-1:0] s0_i;
  logic                s1_valid;
  logic                s1_ready;
  logic signed [N-1:0] s1_r;
  logic signed [N-1:0] s1_i;
  logic                Hq_in_valid;
  logic signed [N-1:0] Hq_in_r;
  logic signed [N-1:0] Hq_in_i;
  logic                G_row_valid;
  logic                done;
  logic                row_src;
  logic [1:0]          row_idx;
  logic                busy;
  logic [7:0]          blk_cnt0;
  logic [7:0]          blk_cnt1;
  logic                err;

  modport slave (
    input  s0_valid, s0_r, s0_i, s1_valid, s1_r, s1_i, G_row_valid, done,
    output s0_ready, s1_ready, Hq_in_valid, Hq_in_r, Hq_in_i,
           row_src, row_idx, busy, blk_cnt0, blk_cnt1, err
  );

  modport master (
    output s0_valid, s0_r, s0_i, s1_valid, s1_r, s1_i, G_row_valid, done,
    input  s0_ready, s1_ready, Hq_in_valid, Hq_in_r, Hq_in_i,
           row_src, row_idx, busy, blk_cnt0, blk_cnt1, err
  );
endinterface

// File: rtl/g_calc_scheduler.sv
// Round-robin scheduler feeding 8-beat Hq blocks from two sources into a G-matrix
// calculator, tracking returned G rows, completions per source and protocol errors.
module g_calc_scheduler #(
  parameter int N        = 16,
  parameter int PRE_BEAT = 1,
  parameter int TIMEOUT  = 64
) (
  input logic               clk,
  input logic               rst_n,
  g_calc_scheduler_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_LOAD = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  localparam int unsigned    WCW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCW-1:0] W_LAST = WCW'(TIMEOUT - 1);

  logic [1:0]          r_state;
  logic                r_gnt;
  logic                r_last_grant;
  logic [2:0]          r_beat_cnt;
  logic [WCW-1:0]      r_wait_cnt;
  logic                r_hq_valid;
  logic signed [N-1:0] r_hq_r;
  logic signed [N-1:0] r_hq_i;
  logic [1:0]          r_row_idx;
  logic [7:0]          r_blk_cnt0;
  logic [7:0]          r_blk_cnt1;
  logic                r_err;

  logic                w_any_req;
  logic                w_pick;
  logic                w_in_load;
  logic                w_in_wait;
  logic                w_xfer;
  logic                w_last_beat;
  logic signed [N-1:0] w_src_r;
  logic signed [N-1:0] w_src_i;
  logic                w_done;
  logic                w_timeout;
  logic                w_stray;

  always_comb begin
    w_any_req   = bus.s0_valid | bus.s1_valid;
    // On a tie grant the source that was not served last; otherwise the lone requester.
    w_pick      = (bus.s0_valid && bus.s1_valid) ? ~r_last_grant : bus.s1_valid;
    w_in_load   = (r_state == S_LOAD);
    w_in_wait   = (r_state == S_WAIT);
    w_xfer      = w_in_load && (r_gnt ? bus.s1_valid : bus.s0_valid);
    w_last_beat = w_xfer && (r_beat_cnt == 3'd7);
    w_src_r     = r_gnt ? bus.s1_r : bus.s0_r;
    w_src_i     = r_gnt ? bus.s1_i : bus.s0_i;
    w_done      = w_in_wait && bus.done;
    // done wins over an expiring wait counter in the same cycle.
    w_timeout   = w_in_wait && !bus.done && (r_wait_cnt == W_LAST);
    w_stray     = !w_in_wait && (bus.G_row_valid || bus.done);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_gnt        <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_gnt   <= w_pick;
            r_state <= (PRE_BEAT != 0) ? S_PRE : S_LOAD;
          end
        end
        S_PRE:  r_state <= S_LOAD;
        S_LOAD: begin
          if (w_last_beat) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_done || w_timeout) begin
            r_state      <= S_IDLE;
            r_last_grant <= r_gnt;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt <= '0;
    end else if (w_last_beat) begin
      r_beat_cnt <= '0;
    end else if (w_xfer) begin
      r_beat_cnt <= r_beat_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (!w_in_wait || w_done || w_timeout) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // Pre-beat and accepted beats share the output register; data holds between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hq_valid <= 1'b0;
      r_hq_r     <= '0;
      r_hq_i     <= '0;
    end else if (r_state == S_PRE) begin
      r_hq_valid <= 1'b1;
      r_hq_r     <= '0;
      r_hq_i     <= '0;
    end else if (w_xfer) begin
      r_hq_valid <= 1'b1;
      r_hq_r     <= w_src_r;
      r_hq_i     <= w_src_i;
    end else begin
      r_hq_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_idx <= '0;
    end else if (w_last_beat) begin
      r_row_idx <= '0;
    end else if (w_in_wait && bus.G_row_valid) begin
      r_row_idx <= r_row_idx + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk_cnt0 <= '0;
      r_blk_cnt1 <= '0;
    end else if (w_done) begin
      if (!r_gnt && (r_blk_cnt0 != '1)) r_blk_cnt0 <= r_blk_cnt0 + 8'd1;
      if (r_gnt && (r_blk_cnt1 != '1))  r_blk_cnt1 <= r_blk_cnt1 + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_stray || w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign bus.s0_ready    = w_in_load && !r_gnt;
  assign bus.s1_ready    = w_in_load && r_gnt;
  assign bus.Hq_in_valid = r_hq_valid;
  assign bus.Hq_in_r     = r_hq_r;
  assign bus.Hq_in_i     = r_hq_i;
  assign bus.row_src     = r_gnt;
  assign bus.row_idx     = r_row_idx;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.blk_cnt0    = r_blk_cnt0;
  assign bus.blk_cnt1    = r_blk_cnt1;
  assign bus.err         = r_err;

endmodule
